// File: rtl/e203_ifu_predec_queue_pkg.sv
// rtl/e203_ifu_predec_queue_pkg.sv - opcode constants and per-entry decode record
package e203_ifu_predec_queue_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BXX    = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  typedef struct packed {
    logic        rv32;
    logic        jal;
    logic        jalr;
    logic        bxx;
    logic        muldiv;
    logic        buserr;
    logic        prdt_taken;
    logic [31:0] imm;
  } predec_t;

endpackage

// File: rtl/e203_ifu_predec_lite.sv
// rtl/e203_ifu_predec_lite.sv - combinational mini-decode and static next-PC prediction
module e203_ifu_predec_lite
  import e203_ifu_predec_queue_pkg::*;
#(
  parameter int PC_SIZE     = 32,
  parameter int STATIC_PRDT = 1
) (
  input  logic [31:0]        instr_i,
  input  logic [PC_SIZE-1:0] pc_i,
  input  logic               buserr_i,
  output predec_t            dec_o,
  output logic [PC_SIZE-1:0] prdt_pc_o
);

  localparam logic               SPRDT = (STATIC_PRDT != 0);
  localparam logic [PC_SIZE-1:0] STEP4 = PC_SIZE'(4);
  localparam logic [PC_SIZE-1:0] STEP2 = PC_SIZE'(2);

  logic        rv32, jal, jalr, bxx, muldiv, taken;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_j, imm_i, imm_b, imm;

  assign opc  = instr_i[6:0];
  assign f3   = instr_i[14:12];
  assign f7   = instr_i[31:25];
  assign rv32 = (instr_i[1:0] == 2'b11);

  // A bus error means the word is garbage: suppress every class flag.
  assign jal    = rv32 & ~buserr_i & (opc == OPC_JAL);
  assign jalr   = rv32 & ~buserr_i & (opc == OPC_JALR) & (f3 == 3'b000);
  assign bxx    = rv32 & ~buserr_i & (opc == OPC_BXX) & (f3 != 3'b010) & (f3 != 3'b011);
  assign muldiv = rv32 & ~buserr_i & (opc == OPC_OP) & (f7 == F7_MULDIV);

  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  always_comb begin
    imm = '0;
    if (jal)       imm = imm_j;
    else if (jalr) imm = imm_i;
    else if (bxx)  imm = imm_b;
  end

  assign taken     = jal | (SPRDT & bxx & imm_b[31]);
  assign prdt_pc_o = taken ? (pc_i + imm[PC_SIZE-1:0])
                           : (pc_i + ((rv32 | buserr_i) ? STEP4 : STEP2));

  always_comb begin
    dec_o            = '0;
    dec_o.rv32       = rv32;
    dec_o.jal        = jal;
    dec_o.jalr       = jalr;
    dec_o.bxx        = bxx;
    dec_o.muldiv     = muldiv;
    dec_o.buserr     = buserr_i;
    dec_o.prdt_taken = taken;
    dec_o.imm        = imm;
  end

endmodule

// File: rtl/e203_ifu_predec_queue.sv
// rtl/e203_ifu_predec_queue.sv - pre-decoded instruction queue between fetch and IR stage
module e203_ifu_predec_queue
  import e203_ifu_predec_queue_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int PC_SIZE     = 32,
  parameter int STATIC_PRDT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [31:0]                i_instr,
  input  logic [PC_SIZE-1:0]         i_pc,
  input  logic                       i_buserr,
  input  logic                       flush,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [31:0]                o_instr,
  output logic [PC_SIZE-1:0]         o_pc,
  output logic                       o_buserr,
  output logic                       o_rv32,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_bxx,
  output logic                       o_bjp,
  output logic                       o_muldiv,
  output logic [4:0]                 o_jalr_rs1idx,
  output logic [31:0]                o_bjp_imm,
  output logic                       o_prdt_taken,
  output logic [PC_SIZE-1:0]         o_prdt_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  predec_t            dec;
  logic [PC_SIZE-1:0] prdt_pc;

  e203_ifu_predec_lite #(
    .PC_SIZE     (PC_SIZE),
    .STATIC_PRDT (STATIC_PRDT)
  ) u_lite (
    .instr_i   (i_instr),
    .pc_i      (i_pc),
    .buserr_i  (i_buserr),
    .dec_o     (dec),
    .prdt_pc_o (prdt_pc)
  );

  predec_t            dec_mem   [DEPTH];
  logic [31:0]        instr_mem [DEPTH];
  logic [PC_SIZE-1:0] pc_mem    [DEPTH];
  logic [PC_SIZE-1:0] ppc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  assign i_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
  assign o_valid = (count_q != '0);
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready & ~flush;

  // Pointers wrap by explicit compare so any DEPTH works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dec_mem[wr_ptr_q]   <= dec;
      instr_mem[wr_ptr_q] <= i_instr;
      pc_mem[wr_ptr_q]    <= i_pc;
      ppc_mem[wr_ptr_q]   <= prdt_pc;
    end
  end

  predec_t head;
  assign head          = dec_mem[rd_ptr_q];
  assign o_instr       = instr_mem[rd_ptr_q];
  assign o_pc          = pc_mem[rd_ptr_q];
  assign o_prdt_pc     = ppc_mem[rd_ptr_q];
  assign o_buserr      = head.buserr;
  assign o_rv32        = head.rv32;
  assign o_jal         = head.jal;
  assign o_jalr        = head.jalr;
  assign o_bxx         = head.bxx;
  assign o_bjp         = head.jal | head.jalr | head.bxx;
  assign o_muldiv      = head.muldiv;
  assign o_jalr_rs1idx = o_instr[19:15];
  assign o_bjp_imm     = head.imm;
  assign o_prdt_taken  = head.prdt_taken;
  assign o_count       = count_q;

endmodule
